ftdi_sync245_tx: RTL and testbench
==================================

Name: ftdi_sync245_tx

Overview:
- Downstream stage of the FIFO-to-FTDI read controller, in the ftdi_clk domain.
- Takes the controller's fifo_rdreq and the FIFO's q output, and drives the FT232H synchronous-245 write pins: data, WR#, SIWU#.
- A small skid buffer absorbs FIFO read latency, so no byte is lost or duplicated when TXE# deasserts mid-burst.
- Returns ftdi_rx_rdy to the controller and flushes partial USB packets with a SIWU# pulse.

Parameters:
- FIFO_RD_LATENCY, 1, cycles from fifo_rdreq to valid fifo_q (non-show-ahead FIFO); legal 1..3.
- SKID_DEPTH, 4, byte entries in the holding buffer; power of two, at least FIFO_RD_LATENCY+2.
- FLUSH_IDLE_CYCLES, 32, idle cycles after the last accepted byte before the SIWU# pulse; legal 2..255.

Ports:
- ftdi_clk  in  1  60 MHz FTDI clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset; synchronous deassertion is provided externally.
- fifo_rdreq  in  1  read strobe issued by the read controller.
- fifo_q  in  8  FIFO read data, valid FIFO_RD_LATENCY cycles after fifo_rdreq.
- ftdi_rx_rdy  out  1  to controller: a read issued this cycle is guaranteed a buffer slot.
- ftdi_txe_n  in  1  FTDI TX FIFO not-full, active-low.
- ftdi_data  out  8  FTDI data bus (write direction only).
- ftdi_wr_n  out  1  FTDI write strobe, active-low, registered.
- ftdi_siwu_n  out  1  send-immediate strobe, active-low, registered.
- tx_byte_cnt  out  32  count of bytes accepted by the FTDI; wraps modulo 2^32.
- overflow_err  out  1  sticky flag: a push arrived while the buffer was full.

Behaviour:
- Reset (async, reset_n=0): ftdi_wr_n=1, ftdi_siwu_n=1, ftdi_data=0, tx_byte_cnt=0, overflow_err=0, buffer emptied, in-flight pipe cleared, state=IDLE, flush counter=0. ftdi_rx_rdy=0 while reset_n=0.
- Reset mid-burst discards buffered and in-flight bytes. WR# returns high immediately, asynchronously.
- In-flight tracking:
  - A FIFO_RD_LATENCY-deep shift register carries fifo_rdreq.
  - When its output is 1, fifo_q is pushed into the buffer that same edge.
  - inflight = number of 1s in the shift register.
- ftdi_rx_rdy (combinational) = ~ftdi_txe_n AND (occupancy + inflight <= SKID_DEPTH-1-FIFO_RD_LATENCY).
- Acceptance: a byte is accepted at an edge where ftdi_wr_n==0 and ftdi_txe_n==0.
  - On acceptance: pop the head, tx_byte_cnt += 1.
- Output register, next-state rule: if the post-pop/push buffer is non-empty and ftdi_txe_n==0, set ftdi_wr_n=0 and ftdi_data=new head; otherwise ftdi_wr_n=1 and ftdi_data holds its value.
  - Push into an empty buffer: the byte appears on ftdi_data with WR# low on the following edge. Latency from fifo_rdreq to WR# low is FIFO_RD_LATENCY+1 cycles.
  - Simultaneous push and pop: both occur. Occupancy is unchanged; pointers advance modulo SKID_DEPTH.
  - Back-to-back acceptance sustains one byte per cycle while TXE# stays low and the buffer stays non-empty.
- Overflow: a push while occupancy==SKID_DEPTH drops the byte and sets overflow_err (held until reset). This only occurs if the controller ignores ftdi_rx_rdy.
- State machine:
  - IDLE: buffer empty, no in-flight reads. Go to SEND on a push.
  - SEND: WR# may be driven. Go to STALL when ftdi_txe_n=1 with occupancy>0. Go to WAIT_FLUSH when the buffer is empty and inflight==0.
  - STALL: WR# forced high, buffer contents held. Return to SEND on ftdi_txe_n=0; the head byte is re-presented, not skipped.
  - WAIT_FLUSH: the flush counter increments each cycle.
    - Any push returns to SEND and clears the counter.
    - At count FLUSH_IDLE_CYCLES-1, go to FLUSH.
  - FLUSH: ftdi_siwu_n=0 for exactly 1 cycle, then IDLE. A push during FLUSH is still buffered; the next state is SEND.
  - SIWU# is never pulsed from IDLE, so there is no pulse without at least one byte accepted since the last flush.
- tx_byte_cnt 32-bit, no saturation: 0xFFFFFFFF + 1 = 0.

Test Plan:
- Reset, then fifo_rdreq for 8 cycles with q=0x00..0x07 and TXE#=0 → WR# low for 8 consecutive cycles starting 2 cycles after the first rdreq; bytes 0x00..0x07 in order; tx_byte_cnt=8.
- Stream 16 bytes; raise TXE# for 5 cycles after byte 6 is accepted → ftdi_rx_rdy drops the same cycle; WR# high during the stall; resume with byte 7; no loss or duplicate; occupancy never exceeds 4; overflow_err=0.
- Accept 3 bytes, then idle → ftdi_siwu_n low for exactly 1 cycle, 32 cycles after the last acceptance; no second pulse while idle.
- Push 1 byte at flush count 20 → no SIWU# pulse; the counter restarts after that byte is accepted.
- Force fifo_rdreq=1 with TXE#=1 for 6 cycles → the 5th push sets overflow_err=1; it stays set until reset_n=0.
- Assert reset_n=0 mid-burst with 3 bytes buffered → WR#=1 immediately; after release, no stale byte is emitted and tx_byte_cnt=0.

Source files
------------

// File: rtl/ftdi_sync245_tx.sv
// ftdi_sync245_tx: drives FT232H synchronous-245 write pins from a FIFO read port.
// A skid buffer absorbs FIFO read latency so no byte is lost or duplicated when
// TXE# deasserts mid-burst. Partial USB packets are flushed with a SIWU# pulse
// once the link has been idle for FLUSH_IDLE_CYCLES cycles.
module ftdi_sync245_tx #(
  parameter int FIFO_RD_LATENCY   = 1,
  parameter int SKID_DEPTH        = 4,
  parameter int FLUSH_IDLE_CYCLES = 32
) (
  input  logic        ftdi_clk,
  input  logic        reset_n,
  input  logic        fifo_rdreq,
  input  logic [7:0]  fifo_q,
  output logic        ftdi_rx_rdy,
  input  logic        ftdi_txe_n,
  output logic [7:0]  ftdi_data,
  output logic        ftdi_wr_n,
  output logic        ftdi_siwu_n,
  output logic [31:0] tx_byte_cnt,
  output logic        overflow_err
);

  localparam int PTR_W = $clog2(SKID_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int INF_W = 2;
  localparam int SUM_W = OCC_W + 2;
  localparam logic [OCC_W-1:0] FULL_OCC   = OCC_W'(SKID_DEPTH);
  localparam logic [SUM_W-1:0] RDY_LIMIT  = SUM_W'(SKID_DEPTH - 1 - FIFO_RD_LATENCY);
  localparam logic [7:0]       FLUSH_LAST = 8'(FLUSH_IDLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SEND       = 3'd1,
    ST_STALL      = 3'd2,
    ST_WAIT_FLUSH = 3'd3,
    ST_FLUSH      = 3'd4
  } state_t;

  // Number of reads currently travelling through the FIFO latency pipe.
  function automatic logic [INF_W-1:0] count_ones(input logic [FIFO_RD_LATENCY-1:0] v);
    logic [INF_W-1:0] n;
    n = {INF_W{1'b0}};
    for (int i = 0; i < FIFO_RD_LATENCY; i++) begin
      n = n + {{(INF_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  logic [FIFO_RD_LATENCY-1:0] rd_pipe_r;
  logic [FIFO_RD_LATENCY-1:0] pipe_nxt_s;
  logic [7:0]                 mem_r [SKID_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_r;
  logic [PTR_W-1:0]           rd_ptr_r;
  logic [PTR_W-1:0]           rd_ptr_nxt_s;
  logic [OCC_W-1:0]           occ_r;
  logic [OCC_W-1:0]           occ_nxt_s;
  logic [OCC_W-1:0]           occ_after_pop_s;
  logic [INF_W-1:0]           inflight_s;
  logic                       push_s;
  logic                       full_s;
  logic                       push_ok_s;
  logic                       pop_s;
  logic [7:0]                 head_s;
  logic                       wr_n_r;
  logic [7:0]                 data_r;
  logic [31:0]                byte_cnt_r;
  logic                       ovf_r;
  logic                       siwu_n_r;
  logic [7:0]                 flush_cnt_r;
  state_t                     state_r;

  // Buffer bookkeeping: push/pop decisions, next occupancy and next head byte.
  always_comb begin
    pipe_nxt_s    = {FIFO_RD_LATENCY{1'b0}};
    pipe_nxt_s[0] = fifo_rdreq;
    for (int i = 1; i < FIFO_RD_LATENCY; i++) begin
      pipe_nxt_s[i] = rd_pipe_r[i-1];
    end
    push_s          = rd_pipe_r[FIFO_RD_LATENCY-1];
    full_s          = (occ_r == FULL_OCC);
    push_ok_s       = push_s & ~full_s;
    pop_s           = ~wr_n_r & ~ftdi_txe_n;
    occ_after_pop_s = occ_r - OCC_W'(pop_s);
    occ_nxt_s       = occ_after_pop_s + OCC_W'(push_ok_s);
    rd_ptr_nxt_s    = rd_ptr_r + PTR_W'(pop_s);
    inflight_s      = count_ones(rd_pipe_r);
    // When the pop drains the buffer, the only possible new head is the byte arriving now.
    if (occ_after_pop_s == {OCC_W{1'b0}}) begin
      head_s = fifo_q;
    end else begin
      head_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // A read is only granted when its byte, plus everything already owed, still fits.
  always_comb begin
    ftdi_rx_rdy = reset_n & ~ftdi_txe_n &
                  ((SUM_W'(occ_r) + SUM_W'(inflight_s)) <= RDY_LIMIT);
  end

  // Datapath: latency pipe, skid buffer, output register, byte counter, overflow flag.
  always_ff @(posedge ftdi_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pipe_r  <= {FIFO_RD_LATENCY{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      occ_r      <= {OCC_W{1'b0}};
      wr_n_r     <= 1'b1;
      data_r     <= 8'h00;
      byte_cnt_r <= 32'h0000_0000;
      ovf_r      <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else begin
      rd_pipe_r <= pipe_nxt_s;
      occ_r     <= occ_nxt_s;
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= fifo_q;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r   <= rd_ptr_nxt_s;
        byte_cnt_r <= byte_cnt_r + 32'd1;
      end
      if (push_s && full_s) begin
        ovf_r <= 1'b1;
      end
      // Present the next head whenever there is something to send and the FTDI can take it.
      if ((occ_nxt_s != {OCC_W{1'b0}}) && !ftdi_txe_n) begin
        wr_n_r <= 1'b0;
        data_r <= head_s;
      end else begin
        wr_n_r <= 1'b1;
      end
    end
  end

  // Control FSM: tracks send/stall/idle and times the send-immediate flush pulse.
  always_ff @(posedge ftdi_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      flush_cnt_r <= 8'd0;
      siwu_n_r    <= 1'b1;
    end else begin
      siwu_n_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (push_s) begin
            state_r <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (ftdi_txe_n && (occ_r != {OCC_W{1'b0}})) begin
            state_r <= ST_STALL;
          end else if ((occ_nxt_s == {OCC_W{1'b0}}) &&
                       (pipe_nxt_s == {FIFO_RD_LATENCY{1'b0}})) begin
            // Count idle cycles from the edge that emptied the buffer.
            state_r     <= ST_WAIT_FLUSH;
            flush_cnt_r <= 8'd0;
          end
        end
        ST_STALL: begin
          if (!ftdi_txe_n) begin
            state_r <= ST_SEND;
          end
        end
        ST_WAIT_FLUSH: begin
          if (push_s) begin
            state_r     <= ST_SEND;
            flush_cnt_r <= 8'd0;
          end else if (flush_cnt_r == FLUSH_LAST) begin
            state_r     <= ST_FLUSH;
            flush_cnt_r <= 8'd0;
            siwu_n_r    <= 1'b0;
          end else begin
            flush_cnt_r <= flush_cnt_r + 8'd1;
          end
        end
        ST_FLUSH: begin
          if (push_s) begin
            state_r <= ST_SEND;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign ftdi_wr_n    = wr_n_r;
  assign ftdi_data    = data_r;
  assign ftdi_siwu_n  = siwu_n_r;
  assign tx_byte_cnt  = byte_cnt_r;
  assign overflow_err = ovf_r;

endmodule

// File: tb/tb_ftdi_sync245_tx.sv
// Bench for ftdi_sync245_tx: directed stimulus with a modelled 1-cycle FIFO;
// issued bytes go into a scoreboard queue that a negedge monitor drains on
// every FTDI acceptance. Scalar checks are posted to the monitor as requests.
module tb_ftdi_sync245_tx;

  logic        ftdi_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fifo_rdreq = 1'b0;
  logic [7:0]  fifo_q = 8'h00;
  logic        ftdi_rx_rdy;
  logic        ftdi_txe_n = 1'b0;
  logic [7:0]  ftdi_data;
  logic        ftdi_wr_n;
  logic        ftdi_siwu_n;
  logic [31:0] tx_byte_cnt;
  logic        overflow_err;

  ftdi_sync245_tx dut (
    .ftdi_clk     (ftdi_clk),
    .reset_n      (reset_n),
    .fifo_rdreq   (fifo_rdreq),
    .fifo_q       (fifo_q),
    .ftdi_rx_rdy  (ftdi_rx_rdy),
    .ftdi_txe_n   (ftdi_txe_n),
    .ftdi_data    (ftdi_data),
    .ftdi_wr_n    (ftdi_wr_n),
    .ftdi_siwu_n  (ftdi_siwu_n),
    .tx_byte_cnt  (tx_byte_cnt),
    .overflow_err (overflow_err)
  );

  always #5 ftdi_clk = ~ftdi_clk;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } req_t;

  req_t       chk_q[$];
  logic [7:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  req_t       mon_r;
  logic [7:0] mon_e;

  // Stimulus-side state
  logic [7:0]  nv = 8'h00;
  logic        prev_rd = 1'b0;
  int          issued = 0;
  logic        smp_wr, smp_siwu, smp_ovf, smp_rdy;
  logic [31:0] smp_cnt;
  logic [31:0] prev_cnt;
  int          cyc, last_acc, pulses, pulse_at;

  // Monitor: resolves posted checks and scoreboards every accepted byte.
  always @(negedge ftdi_clk) begin
    while (chk_q.size() > 0) begin
      mon_r = chk_q.pop_front();
      n_vec++;
      if (mon_r.act !== mon_r.exp) begin
        n_err++;
        $display("FAIL %s: got %0h, expected %0h", mon_r.name, mon_r.act, mon_r.exp);
      end
    end
    if (reset_n && ftdi_wr_n == 1'b0 && ftdi_txe_n == 1'b0) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL byte: got %0h, expected no byte", ftdi_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (ftdi_data !== mon_e) begin
          n_err++;
          $display("FAIL byte: got %0h, expected %0h", ftdi_data, mon_e);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    req_t r;
    r.name = nm;
    r.act  = act;
    r.exp  = exp;
    chk_q.push_back(r);
  endtask

  task automatic tick();
    @(posedge ftdi_clk);
    #1;
    smp_wr   = ftdi_wr_n;
    smp_siwu = ftdi_siwu_n;
    smp_ovf  = overflow_err;
    smp_cnt  = tx_byte_cnt;
    if (smp_cnt != prev_cnt) begin
      last_acc = cyc;
      prev_cnt = smp_cnt;
    end
    if (!smp_siwu) begin
      pulses++;
      pulse_at = cyc;
    end
    cyc++;
  endtask

  // FIFO model: data for last cycle's read appears now (latency 1).
  task automatic drive(input logic rd, input logic txe, input logic obey);
    if (prev_rd) begin
      fifo_q = nv;
      exp_q.push_back(nv);
      nv = nv + 8'd1;
    end
    ftdi_txe_n = txe;
    #1;
    smp_rdy    = ftdi_rx_rdy;
    fifo_rdreq = rd & (obey ? ftdi_rx_rdy : 1'b1);
    prev_rd    = fifo_rdreq;
    if (fifo_rdreq) issued++;
  endtask

  task automatic begin_window();
    cyc      = 0;
    last_acc = -1000;
    pulses   = 0;
    pulse_at = -1000;
    prev_cnt = tx_byte_cnt;
  endtask

  task automatic do_reset();
    fifo_rdreq = 1'b0;
    reset_n    = 1'b0;
    prev_rd    = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge ftdi_clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] wr_mask;
    logic [31:0] base, cnt_at_stall;
    int          stall_left, obs_left, stall_hi, stall_started, wr_low;
    logic        ovf_hist [12];

    // ---- reset values ----
    @(posedge ftdi_clk);
    #1;
    check("rst_wr_n", 32'(ftdi_wr_n), 32'd1);
    check("rst_siwu_n", 32'(ftdi_siwu_n), 32'd1);
    check("rst_data", 32'(ftdi_data), 32'd0);
    check("rst_cnt", tx_byte_cnt, 32'd0);
    check("rst_ovf", 32'(overflow_err), 32'd0);
    check("rst_rdy", 32'(ftdi_rx_rdy), 32'd0);
    do_reset();
    #1;
    check("rdy_empty", 32'(ftdi_rx_rdy), 32'd1);

    // ---- T1: 8-byte burst, bytes 0x00..0x07 ----
    begin_window();
    wr_mask = 12'h000;
    for (int i = 0; i < 12; i++) begin
      tick();
      wr_mask[i] = smp_wr;
      drive(i < 8, 1'b0, 1'b0);
    end
    check("t1_wr_window", 32'(wr_mask), 32'h0000_0C03);
    for (int i = 0; i < 40; i++) begin
      tick();
      drive(1'b0, 1'b0, 1'b0);
    end
    check("t1_cnt", smp_cnt, 32'd8);

    // ---- T2: 16 bytes, 5-cycle TXE# stall after 7 accepts ----
    base = smp_cnt;
    issued = 0;
    stall_left = 0;
    obs_left = 0;
    stall_hi = 0;
    stall_started = 0;
    cnt_at_stall = 32'd0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (obs_left > 0) begin
        stall_hi += int'(smp_wr);
        obs_left--;
        if (obs_left == 0) check("t2_cnt_hold", smp_cnt, cnt_at_stall);
      end
      if (stall_started == 0 && smp_cnt == base + 32'd7) begin
        stall_started = 1;
        stall_left = 5;
        obs_left = 5;
        cnt_at_stall = smp_cnt;
      end
      if (stall_left > 0) begin
        drive(issued < 16, 1'b1, 1'b1);
        if (stall_left == 5) check("t2_rdy_drop", 32'(smp_rdy), 32'd0);
        stall_left--;
      end else begin
        drive(issued < 16, 1'b0, 1'b1);
      end
    end
    check("t2_stall_seen", 32'(stall_started), 32'd1);
    check("t2_wr_high_stall", 32'(stall_hi), 32'd5);
    check("t2_total", smp_cnt, base + 32'd16);
    check("t2_ovf", 32'(smp_ovf), 32'd0);

    // ---- T3: 3 bytes then idle -> one SIWU# pulse 32 cycles later ----
    begin_window();
    for (int i = 0; i < 103; i++) begin
      tick();
      drive(i < 3, 1'b0, 1'b0);
    end
    check("t3_pulses", 32'(pulses), 32'd1);
    check("t3_delay", 32'(pulse_at - last_acc), 32'd32);

    // ---- T4: push at flush count 20 cancels the pending flush ----
    begin_window();
    for (int i = 0; i < 110; i++) begin
      tick();
      drive(i == 0 || i == 22, 1'b0, 1'b0);
    end
    check("t4_pulses", 32'(pulses), 32'd1);
    check("t4_delay", 32'(pulse_at - last_acc), 32'd32);

    // ---- T5: overflow when reads ignore ftdi_rx_rdy ----
    begin_window();
    for (int i = 0; i < 12; i++) begin
      tick();
      ovf_hist[i] = smp_ovf;
      drive(i < 6, 1'b1, 1'b0);
    end
    check("t5_ovf_4th", 32'(ovf_hist[5]), 32'd0);
    check("t5_ovf_5th", 32'(ovf_hist[6]), 32'd1);
    repeat (20) begin
      tick();
      drive(1'b0, 1'b1, 1'b0);
    end
    check("t5_ovf_sticky", 32'(smp_ovf), 32'd1);
    do_reset();
    #1;
    check("t5_ovf_cleared", 32'(overflow_err), 32'd0);

    // ---- T6: reset mid-burst with 3 bytes buffered ----
    for (int i = 0; i < 5; i++) begin
      tick();
      drive(i < 3, 1'b1, 1'b0);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0);
    check("t6_rdy_3_buffered", 32'(smp_rdy), 32'd0);
    tick();
    check("t6_wr_before_rst", 32'(smp_wr), 32'd0);
    #2;
    reset_n = 1'b0;
    prev_rd = 1'b0;
    fifo_rdreq = 1'b0;
    exp_q.delete();
    #1;
    check("t6_wr_async", 32'(ftdi_wr_n), 32'd1);
    repeat (2) @(posedge ftdi_clk);
    #1;
    reset_n = 1'b1;
    wr_low = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!smp_wr) wr_low++;
      drive(1'b0, 1'b0, 1'b0);
    end
    check("t6_no_stale", 32'(wr_low), 32'd0);
    check("t6_cnt", smp_cnt, 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge ftdi_clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
